branch_predictor_bht: RTL and testbench

Parametrised branch history table that replaces the fixed predict-taken policy of the pipelined core with per-branch dynamic prediction. It sits beside the PC in the IF stage: it answers a combinational taken/not-taken query for the fetched instruction and is trained by the branch outcome resolved in ID. It also counts branches and mispredictions for performance measurement.

---
 rtl/branch_predictor_bht.sv | 182 ++++++++++++++++++
 tb/tb_branch_predictor_bht.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Branch history table: per-branch saturating counters indexed by low PC bits.
// Combinational lookup with same-index bypass, trained from ID, with stats.
module branch_predictor_bht #(
    parameter int ADDR_W   = 32,
    parameter int IDX_W    = 6,
    parameter int CNT_W    = 2,
    parameter int INIT_CNT = 1,
    parameter int STAT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    input  logic              lookup_is_branch_i,
    output logic              predict_taken_o,
    input  logic              update_valid_i,
    input  logic [ADDR_W-1:0] update_pc_i,
    input  logic              update_taken_i,
    input  logic              update_predicted_i,
    output logic              mispredict_o,
    input  logic              clear_i,
    output logic              busy_o,
    output logic [STAT_W-1:0] branch_cnt_o,
    output logic [STAT_W-1:0] mispredict_cnt_o
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT_CNT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              busy_q, busy_d;
    logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_W-1:0] misp_cnt_q, misp_cnt_d;

    logic [CNT_W-1:0]  table_q [DEPTH];

    logic              ready;
    logic [IDX_W-1:0]  lookup_idx;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_en;
    logic              misp;
    logic [CNT_W-1:0]  upd_old;
    logic [CNT_W-1:0]  upd_new;
    logic [CNT_W-1:0]  lookup_cnt;

    logic              tbl_we;
    logic [IDX_W-1:0]  tbl_waddr;
    logic [CNT_W-1:0]  tbl_wdata;

    // Upper PC bits are not part of the index: no tags, aliasing accepted.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i[ADDR_W-1:IDX_W],
                              update_pc_i[ADDR_W-1:IDX_W]};

    function automatic logic [CNT_W-1:0] sat_step(
        input logic [CNT_W-1:0] cnt,
        input logic             up
    );
        logic [CNT_W-1:0] res;
        res = cnt;
        if (up) begin
            if (cnt != CNT_MAX) res = cnt + 1'b1;
        end else begin
            if (cnt != CNT_ZERO) res = cnt - 1'b1;
        end
        return res;
    endfunction

    // Lookup path: table read, same-index bypass of the pending update.
    always_comb begin
        ready      = (state_q == ST_READY);
        lookup_idx = lookup_pc_i[IDX_W-1:0];
        upd_idx    = update_pc_i[IDX_W-1:0];
        // A clear in the same cycle discards the update entirely.
        upd_en     = ready & update_valid_i & ~clear_i;
        misp       = update_valid_i & (update_taken_i != update_predicted_i);
        upd_old    = table_q[upd_idx];
        upd_new    = sat_step(upd_old, update_taken_i);
        lookup_cnt = table_q[lookup_idx];
        if (upd_en && (upd_idx == lookup_idx)) begin
            lookup_cnt = upd_new;
        end
    end

    assign predict_taken_o  = lookup_is_branch_i & ready & lookup_cnt[CNT_W-1];
    assign mispredict_o     = misp;
    assign busy_o           = busy_q;
    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = misp_cnt_q;

    // Table write port: init sweep in INIT, training in READY.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = idx_q;
        tbl_wdata = INIT_VAL;
        if (state_q == ST_INIT) begin
            tbl_we    = ~clear_i;
            tbl_waddr = idx_q;
            tbl_wdata = INIT_VAL;
        end else if (upd_en) begin
            tbl_we    = 1'b1;
            tbl_waddr = upd_idx;
            tbl_wdata = upd_new;
        end
    end

    // Next-state logic for the sweep FSM and the statistics counters.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        branch_cnt_d = branch_cnt_q;
        misp_cnt_d   = misp_cnt_q;
        unique case (state_q)
            ST_INIT: begin
                if (clear_i) begin
                    idx_d        = '0;
                    branch_cnt_d = '0;
                    misp_cnt_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_READY;
                    end
                end
            end
            ST_READY: begin
                if (clear_i) begin
                    state_d      = ST_INIT;
                    idx_d        = '0;
                    branch_cnt_d = '0;
                    misp_cnt_d   = '0;
                end else if (update_valid_i) begin
                    if (branch_cnt_q != STAT_MAX) begin
                        branch_cnt_d = branch_cnt_q + 1'b1;
                    end
                    if (misp && (misp_cnt_q != STAT_MAX)) begin
                        misp_cnt_d = misp_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_INIT);
    end

    // Control and statistics registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_INIT;
            idx_q        <= '0;
            busy_q       <= 1'b1;
            branch_cnt_q <= '0;
            misp_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            branch_cnt_q <= branch_cnt_d;
            misp_cnt_q   <= misp_cnt_d;
        end
    end

    // Counter storage; no reset because the init sweep defines every entry.
    always_ff @(posedge clk_i) begin
        if (tbl_we) begin
            table_q[tbl_waddr] <= tbl_wdata;
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Randomised and directed bench for branch_predictor_bht.
// Reference model: integer counters per index, a busy countdown, plain stat counts.
module tb_branch_predictor_bht;

    localparam int DEPTH = 64;
    localparam int SMAX  = 65535;
    localparam int SSMAX = 15;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] lookup_pc_i = '0;
    logic        lookup_is_branch_i = 1'b0;
    logic        update_valid_i = 1'b0;
    logic [31:0] update_pc_i = '0;
    logic        update_taken_i = 1'b0;
    logic        update_predicted_i = 1'b0;
    logic        clear_i = 1'b0;

    logic        predict_taken_o, mispredict_o, busy_o;
    logic [15:0] branch_cnt_o, mispredict_cnt_o;
    logic        s_predict, s_misp, s_busy;
    logic [3:0]  s_br, s_mp;

    always #5 clk_i = ~clk_i;

    branch_predictor_bht dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .lookup_pc_i        (lookup_pc_i),
        .lookup_is_branch_i (lookup_is_branch_i),
        .predict_taken_o    (predict_taken_o),
        .update_valid_i     (update_valid_i),
        .update_pc_i        (update_pc_i),
        .update_taken_i     (update_taken_i),
        .update_predicted_i (update_predicted_i),
        .mispredict_o       (mispredict_o),
        .clear_i            (clear_i),
        .busy_o             (busy_o),
        .branch_cnt_o       (branch_cnt_o),
        .mispredict_cnt_o   (mispredict_cnt_o)
    );

    branch_predictor_bht #(.STAT_W(4)) dut_s (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .lookup_pc_i        (lookup_pc_i),
        .lookup_is_branch_i (lookup_is_branch_i),
        .predict_taken_o    (s_predict),
        .update_valid_i     (update_valid_i),
        .update_pc_i        (update_pc_i),
        .update_taken_i     (update_taken_i),
        .update_predicted_i (update_predicted_i),
        .mispredict_o       (s_misp),
        .clear_i            (clear_i),
        .busy_o             (s_busy),
        .branch_cnt_o       (s_br),
        .mispredict_cnt_o   (s_mp)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int mtab [DEPTH];
    int busy_left;
    int mbr;
    int mmp;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clip(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) mtab[i] = 1;
        busy_left = DEPTH;
        mbr = 0;
        mmp = 0;
    endfunction

    function automatic bit m_pred();
        int v;
        int li;
        int ui;
        if (busy_left != 0 || !lookup_is_branch_i) return 1'b0;
        li = int'(lookup_pc_i % DEPTH);
        ui = int'(update_pc_i % DEPTH);
        v = mtab[li];
        if (update_valid_i && !clear_i && ui == li)
            v = clip(v + (update_taken_i ? 1 : -1), 0, 3);
        return v >= 2;
    endfunction

    function automatic void m_edge();
        int ui;
        if (rst_i || clear_i) begin
            m_reset();
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (update_valid_i) begin
            ui = int'(update_pc_i % DEPTH);
            mtab[ui] = clip(mtab[ui] + (update_taken_i ? 1 : -1), 0, 3);
            mbr++;
            if (update_taken_i != update_predicted_i) mmp++;
        end
    endfunction

    // Check every output against the model, then advance one clock.
    task automatic step();
        #1;
        if (rst_i) m_reset();
        chk("predict", 32'(predict_taken_o), 32'(m_pred()));
        chk("mispredict", 32'(mispredict_o),
            32'(update_valid_i && (update_taken_i != update_predicted_i)));
        chk("busy", 32'(busy_o), 32'(busy_left != 0));
        chk("branch_cnt", 32'(branch_cnt_o), 32'(clip(mbr, 0, SMAX)));
        chk("misp_cnt", 32'(mispredict_cnt_o), 32'(clip(mmp, 0, SMAX)));
        chk("s_branch_cnt", 32'(s_br), 32'(clip(mbr, 0, SSMAX)));
        chk("s_misp_cnt", 32'(s_mp), 32'(clip(mmp, 0, SSMAX)));
        @(posedge clk_i);
        m_edge();
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            update_valid_i     = 1'b0;
            lookup_is_branch_i = 1'b1;
            lookup_pc_i        = $urandom;
            step();
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic pr);
        lookup_is_branch_i = 1'b0;
        update_valid_i     = 1'b1;
        update_pc_i        = pc;
        update_taken_i     = tk;
        update_predicted_i = pr;
        step();
        update_valid_i     = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp);
        update_valid_i     = 1'b0;
        lookup_is_branch_i = 1'b1;
        lookup_pc_i        = pc;
        #1 chk(tag, 32'(predict_taken_o), 32'(exp));
        step();
    endtask

    int pulses;
    int busy_n;

    initial begin
        m_reset();
        @(negedge clk_i);
        step();
        rst_i = 1'b0;
        idle(DEPTH);
        chk("busy_after_sweep", 32'(busy_o), 32'd0);
        chk("cnt_after_reset", 32'(branch_cnt_o), 32'd0);

        upd(32'h10, 1'b1, 1'b0);
        upd(32'h10, 1'b1, 1'b0);
        look("p10_tt", 32'h10, 1'b1);
        upd(32'h10, 1'b1, 1'b1);
        upd(32'h10, 1'b1, 1'b1);
        upd(32'h10, 1'b0, 1'b1);
        look("p10_sat_n", 32'h10, 1'b1);
        upd(32'h10, 1'b0, 1'b1);
        look("p10_sat_nn", 32'h10, 1'b0);

        upd(32'h05, 1'b1, 1'b0);
        upd(32'h05, 1'b1, 1'b0);
        look("alias_45", 32'h45, 1'b1);
        look("alias_06", 32'h06, 1'b0);

        lookup_is_branch_i = 1'b1;
        lookup_pc_i        = 32'h20;
        update_valid_i     = 1'b1;
        update_pc_i        = 32'h20;
        update_taken_i     = 1'b1;
        update_predicted_i = 1'b0;
        #1 chk("bypass_20", 32'(predict_taken_o), 32'd1);
        step();
        update_valid_i = 1'b0;

        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        idle(DEPTH);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            lookup_is_branch_i = 1'b0;
            update_valid_i     = 1'b1;
            update_pc_i        = 32'(k * 3);
            update_taken_i     = k[0];
            update_predicted_i = (k == 2 || k == 5 || k == 8) ? ~k[0] : k[0];
            #1 if (mispredict_o) pulses++;
            step();
        end
        update_valid_i = 1'b0;
        chk("stat_branch10", 32'(branch_cnt_o), 32'd10);
        chk("stat_misp3", 32'(mispredict_cnt_o), 32'd3);
        chk("misp_pulses", 32'(pulses), 32'd3);
        for (int k = 0; k < 10; k++) upd(32'(k), 1'b1, 1'b1);
        chk("stat_branch20", 32'(branch_cnt_o), 32'd20);
        chk("stat4_sat15", 32'(s_br), 32'd15);

        update_valid_i     = 1'b1;
        update_pc_i        = 32'h30;
        update_taken_i     = 1'b1;
        update_predicted_i = 1'b0;
        clear_i            = 1'b1;
        step();
        clear_i        = 1'b0;
        update_valid_i = 1'b0;
        chk("clear_br0", 32'(branch_cnt_o), 32'd0);
        chk("clear_mp0", 32'(mispredict_cnt_o), 32'd0);
        busy_n = 0;
        for (int i = 0; i < 200 && busy_o; i++) begin
            busy_n++;
            idle(1);
        end
        chk("clear_busy64", 32'(busy_n), 32'd64);
        look("clr_p10", 32'h10, 1'b0);
        look("clr_p05", 32'h05, 1'b0);
        look("clr_p30", 32'h30, 1'b0);
        look("clr_p03", 32'h03, 1'b0);

        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        idle(30);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 200 && busy_o; i++) begin
            busy_n++;
            idle(1);
        end
        chk("rst_busy64", 32'(busy_n), 32'd64);

        for (int i = 0; i < 3000; i++) begin
            rst_i              = ($urandom_range(0, 499) == 0);
            clear_i            = ($urandom_range(0, 199) == 0);
            lookup_is_branch_i = $urandom_range(0, 1);
            lookup_pc_i        = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 15));
            update_valid_i     = $urandom_range(0, 1);
            update_pc_i        = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 15));
            update_taken_i     = $urandom_range(0, 1);
            update_predicted_i = $urandom_range(0, 1);
            step();
        end
        rst_i   = 1'b0;
        clear_i = 1'b0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
